id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the 5-stage MIPS core with integrated operand forwarding and load-use hazard detection. It captures decoded fields and register-file read data at the end of ID and presents forwarded ALU operands to EX. Forwarding sources are EX/MEM and MEM/WB. When a load in EX feeds the instruction in ID, it raises `stall` and inserts a bubble.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_W`, 5, register index width
- `CNT_W`, 16, bubble counter width

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  branch/jump flush: discard the ID instruction
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  REG_W  source register indices
- `id_uses_rt`  in  1  instruction reads rt as a source (R-type, store, branch)
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_dest`  in  REG_W  destination register
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_alusrc`  in  1  controls
- `id_alu_ctrl`  in  4  ALU operation
- `exmem_regwrite`  in  1, `exmem_dest`  in  REG_W, `exmem_result`  in  DATA_W  EX/MEM forward source
- `memwb_regwrite`  in  1, `memwb_dest`  in  REG_W, `memwb_result`  in  DATA_W  MEM/WB forward source (value being written back this cycle)
- `stall`  out  1  hold PC and IF/ID (combinational)
- `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_alusrc`  out  1  registered controls
- `ex_alu_ctrl`  out  4; `ex_dest`, `ex_rs`, `ex_rt`  out  REG_W; `ex_imm`  out  DATA_W  registered
- `ex_opa`  out  DATA_W  forwarded rs operand (combinational)
- `ex_rt_val`  out  DATA_W  forwarded rt value (store data)
- `ex_opb`  out  DATA_W  `ex_alusrc ? ex_imm : ex_rt_val`
- `fwd_a`, `fwd_b`  out  2  forward select: 0 = register, 1 = MEM/WB, 2 = EX/MEM
- `bubble_cnt`  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- Load-use detect: `stall = id_valid & ex_valid & ex_memread & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)) & ~flush`.
- Register update, evaluated at each posedge in this priority:
  - `reset`: all registered outputs are 0; `bubble_cnt` is 0.
  - `flush`: capture a bubble. Bubble = `ex_valid`, all controls, `ex_dest`, `ex_rs` and `ex_rt` are 0.
  - `stall`: capture a bubble and increment `bubble_cnt`. `bubble_cnt` saturates at all-ones.
  - Otherwise: capture all ID fields.
  - `ex_valid = id_valid`. When `id_valid = 0`, capture a bubble.
- WB write-through at capture: if `memwb_regwrite` and `memwb_dest != 0` and `memwb_dest == id_rs`, latch `memwb_result` instead of `id_rs_data`. Apply the same rule to rt. This covers a register file without internal bypass.
- Forward select for the rs operand, combinational on the registered fields; the rt operand uses the same rule:
  - `exmem_regwrite & exmem_dest != 0 & exmem_dest == ex_rs` → 2.
  - Else `memwb_regwrite & memwb_dest != 0 & memwb_dest == ex_rs` → 1.
  - Else → 0.
  - EX/MEM has priority over MEM/WB (the younger producer wins).
- Register 0 is never forwarded or bypassed; the register value (0) is used.
- A bubble has `ex_rs = ex_rt = 0`, so `fwd_a = fwd_b = 0`.

## Timing
- Latency: ID fields appear on `ex_*` one cycle after capture.
- `ex_opa`, `ex_opb`, `ex_rt_val`, `fwd_a`, `fwd_b` and `stall` are same-cycle combinational. There is no path from `stall` back to itself.
- Load-use costs exactly one bubble. In the cycle after the stall, `ex_memread` belongs to the bubble, so `stall` drops and the held ID instruction is captured. The load value is then forwarded from MEM/WB.
- `flush` and `stall` in the same cycle: `flush` wins, `stall = 0`, and `bubble_cnt` is unchanged.
- `reset` mid-stall clears the register; `stall` is 0 on the following cycle.

## Test plan
- Back-to-back ALU dependency: `add r3,r1,r2` then `sub r4,r3,r5`. In the `sub` EX cycle with `exmem_dest=3` and `exmem_result=0x0000_0010`: `fwd_a=2` and `ex_opa=0x10`.
- Double hazard: `exmem_dest=memwb_dest=7` with results 0xAA and 0xBB, `ex_rs=7` → `fwd_a=2`, `ex_opa=0xAA`. Clear `exmem_regwrite` → `fwd_a=1`, `ex_opa=0xBB`.
- Load-use: `lw r8,0(r1)` in EX, `add r9,r8,r2` in ID → `stall=1` for exactly one cycle. The next EX is a bubble, `bubble_cnt` 0→1. The `add` then enters EX with `fwd_a=1`.
- r0 and write-through:
  - `exmem_dest=0`, `exmem_regwrite=1`, `ex_rs=0` → `fwd_a=0`, `ex_opa=0`.
  - Capture with `memwb_dest=id_rt=4`, `memwb_result=0x1234`, stale `id_rt_data=0` → `ex_rt_val=0x1234`.
- Flush priority: `flush=1` together with a load-use condition → `stall=0`, the next `ex_valid=0`, and `bubble_cnt` is unchanged.
- Reset and saturation:
  - Assert `reset` during a stall → the next cycle has all `ex_*=0` and `bubble_cnt=0`.
  - With `CNT_W=2`, force 5 load-use stalls → `bubble_cnt=3`.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields and forward sources in, registered EX fields and operands out.
// master = pipeline side driving ID/forward sources; slave = the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic              id_alusrc;
    logic [3:0]        id_alu_ctrl;

    logic              exmem_regwrite;
    logic [REG_W-1:0]  exmem_dest;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_regwrite;
    logic [REG_W-1:0]  memwb_dest;
    logic [DATA_W-1:0] memwb_result;

    logic              stall;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_alusrc;
    logic [3:0]        ex_alu_ctrl;
    logic [REG_W-1:0]  ex_dest;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_opa;
    logic [DATA_W-1:0] ex_rt_val;
    logic [DATA_W-1:0] ex_opb;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, id_valid, id_rs, id_rt, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_dest, id_regwrite, id_memread, id_memwrite, id_alusrc, id_alu_ctrl,
               exmem_regwrite, exmem_dest, exmem_result, memwb_regwrite, memwb_dest, memwb_result,
        input  stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_alu_ctrl,
               ex_dest, ex_rs, ex_rt, ex_imm, ex_opa, ex_rt_val, ex_opb, fwd_a, fwd_b, bubble_cnt
    );

    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_dest, id_regwrite, id_memread, id_memwrite, id_alusrc, id_alu_ctrl,
               exmem_regwrite, exmem_dest, exmem_result, memwb_regwrite, memwb_dest, memwb_result,
        output stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc, ex_alu_ctrl,
               ex_dest, ex_rs, ex_rt, ex_imm, ex_opa, ex_rt_val, ex_opb, fwd_a, fwd_b, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding and load-use bubble insertion.
// Latency: ID fields appear on ex_* one cycle after capture; stall and forwarded operands are combinational.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              alusrc;
        logic [3:0]        alu_ctrl;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
    } ex_reg_t;

    ex_reg_t           ex_q, ex_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall;
    logic [1:0]        fwd_a, fwd_b;
    logic [DATA_W-1:0] opa, rt_val;

    // r0 is hardwired: a write to it never matches a consumer.
    function automatic logic hit(input logic rw, input logic [REG_W-1:0] dst,
                                 input logic [REG_W-1:0] src);
        return rw && (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (hit(bus.exmem_regwrite, bus.exmem_dest, src))
            return 2'd2;
        else if (hit(bus.memwb_regwrite, bus.memwb_dest, src))
            return 2'd1;
        return 2'd0;
    endfunction

    // Depends only on ID inputs and registered EX fields, so no loop through stall.
    assign stall = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.dest != '0)
                 & ((ex_q.dest == bus.id_rs) | (bus.id_uses_rt & (ex_q.dest == bus.id_rt)))
                 & ~bus.flush;

    always_comb begin
        ex_d  = '0;
        cnt_d = cnt_q;
        if (!bus.flush) begin
            if (stall) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end else if (bus.id_valid) begin
                ex_d.valid    = 1'b1;
                ex_d.regwrite = bus.id_regwrite;
                ex_d.memread  = bus.id_memread;
                ex_d.memwrite = bus.id_memwrite;
                ex_d.alusrc   = bus.id_alusrc;
                ex_d.alu_ctrl = bus.id_alu_ctrl;
                ex_d.dest     = bus.id_dest;
                ex_d.rs       = bus.id_rs;
                ex_d.rt       = bus.id_rt;
                ex_d.imm      = bus.id_imm;
                // Register file has no internal bypass: take the value being written back now.
                ex_d.rs_data  = hit(bus.memwb_regwrite, bus.memwb_dest, bus.id_rs)
                              ? bus.memwb_result : bus.id_rs_data;
                ex_d.rt_data  = hit(bus.memwb_regwrite, bus.memwb_dest, bus.id_rt)
                              ? bus.memwb_result : bus.id_rt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(ex_q.rs);
        fwd_b = fwd_sel(ex_q.rt);
        case (fwd_a)
            2'd2:    opa = bus.exmem_result;
            2'd1:    opa = bus.memwb_result;
            default: opa = ex_q.rs_data;
        endcase
        case (fwd_b)
            2'd2:    rt_val = bus.exmem_result;
            2'd1:    rt_val = bus.memwb_result;
            default: rt_val = ex_q.rt_data;
        endcase
    end

    assign bus.stall       = stall;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_memwrite = ex_q.memwrite;
    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_alu_ctrl = ex_q.alu_ctrl;
    assign bus.ex_dest     = ex_q.dest;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_opa      = opa;
    assign bus.ex_rt_val   = rt_val;
    assign bus.ex_opb      = ex_q.alusrc ? ex_q.imm : rt_val;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: cycle table with expected registered results queued per capture,
// plus directed sequences for double hazard, reset during stall and counter saturation (CNT_W=2).
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 2;

    typedef struct packed {
        logic        vld, urt, rw, mr, mw, src;
        logic [3:0]  alu;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
    } instr_t;

    typedef struct packed {
        logic        xrw;
        logic [4:0]  xd;
        logic [31:0] xr;
        logic        mrw;
        logic [4:0]  md;
        logic [31:0] mres;
    } fwd_t;

    typedef struct {
        logic        flush;
        instr_t      id;
        fwd_t        f;
        logic        e_stall, chk_ops;
        logic [1:0]  e_fa, e_fb;
        logic [31:0] e_opa, e_rtv, e_opb;
        logic        n_v;
        logic [4:0]  n_d;
        logic        n_mr;
        logic [1:0]  n_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        v;
        logic [4:0]  d;
        logic        mr;
        logic [1:0]  cnt;
    } nxt_t;

    logic clk;
    logic reset;
    id_ex_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    nxt_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic instr_t mk_i(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic urt, input logic [31:0] rsd, input logic [31:0] rtd,
                                    input logic [31:0] imm, input logic [4:0] dest, input logic rw,
                                    input logic mr, input logic mw, input logic src,
                                    input logic [3:0] alu);
        instr_t r;
        r.vld = vld; r.rs = rs; r.rt = rt; r.urt = urt; r.rsd = rsd; r.rtd = rtd; r.imm = imm;
        r.dest = dest; r.rw = rw; r.mr = mr; r.mw = mw; r.src = src; r.alu = alu;
        return r;
    endfunction

    function automatic fwd_t mk_f(input logic xrw, input logic [4:0] xd, input logic [31:0] xr,
                                  input logic mrw, input logic [4:0] md, input logic [31:0] mres);
        fwd_t r;
        r.xrw = xrw; r.xd = xd; r.xr = xr; r.mrw = mrw; r.md = md; r.mres = mres;
        return r;
    endfunction

    task automatic add_vec(input logic fl, input instr_t id, input fwd_t f, input logic st,
                           input logic co, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] opa, input logic [31:0] rtv, input logic [31:0] opb,
                           input logic nv, input logic [4:0] nd, input logic nmr,
                           input logic [1:0] ncnt);
        vec_t v;
        v.flush = fl; v.id = id; v.f = f; v.e_stall = st; v.chk_ops = co;
        v.e_fa = fa; v.e_fb = fb; v.e_opa = opa; v.e_rtv = rtv; v.e_opb = opb;
        v.n_v = nv; v.n_d = nd; v.n_mr = nmr; v.n_cnt = ncnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic fl, input instr_t i, input fwd_t f);
        bus.flush = fl;
        bus.id_valid = i.vld; bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_uses_rt = i.urt;
        bus.id_rs_data = i.rsd; bus.id_rt_data = i.rtd; bus.id_imm = i.imm; bus.id_dest = i.dest;
        bus.id_regwrite = i.rw; bus.id_memread = i.mr; bus.id_memwrite = i.mw;
        bus.id_alusrc = i.src; bus.id_alu_ctrl = i.alu;
        bus.exmem_regwrite = f.xrw; bus.exmem_dest = f.xd; bus.exmem_result = f.xr;
        bus.memwb_regwrite = f.mrw; bus.memwb_dest = f.md; bus.memwb_result = f.mres;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop, lw8, add9, or11, addi6;
        fwd_t   f0;
        vec_t   v;
        nxt_t   e;
        nop   = '0;
        f0    = '0;
        lw8   = mk_i(1, 1, 8, 0, 32'h200, 32'h3, 0, 8, 1, 1, 0, 1, 2);
        add9  = mk_i(1, 8, 2, 1, 32'hDEAD, 32'h4, 0, 9, 1, 0, 0, 0, 2);
        or11  = mk_i(1, 1, 8, 1, 32'h1, 32'h2, 0, 11, 1, 0, 0, 0, 1);
        addi6 = mk_i(1, 7, 0, 0, 32'h11, 0, 32'h20, 6, 1, 0, 0, 1, 2);

        //      fl  ID instruction                                          forward sources
        //      stall chk fa fb  opa        rt_val      opb           next: v  dest mr cnt
        add_vec(0, mk_i(1, 1, 2, 1, 5, 7, 0, 3, 1, 0, 0, 0, 2),            f0,
                0, 1, 0, 0, 0, 0, 0,                                       1, 3, 0, 0);
        add_vec(0, mk_i(1, 3, 5, 1, 0, 9, 0, 4, 1, 0, 0, 0, 6),            f0,
                0, 1, 0, 0, 5, 7, 7,                                       1, 4, 0, 0);
        add_vec(0, mk_i(0, 3, 5, 1, 0, 9, 0, 12, 1, 1, 0, 0, 6),           mk_f(1, 3, 32'h10, 0, 0, 0),
                0, 1, 2, 0, 32'h10, 9, 9,                                  0, 0, 0, 0);
        add_vec(0, mk_i(1, 0, 5, 1, 0, 32'h77, 0, 10, 1, 0, 0, 0, 1),      mk_f(0, 0, 0, 1, 0, 32'h99),
                0, 0, 0, 0, 0, 0, 0,                                       1, 10, 0, 0);
        add_vec(0, mk_i(1, 2, 4, 1, 32'h100, 0, 8, 0, 0, 0, 1, 1, 0),      mk_f(1, 0, 32'h55, 1, 4, 32'h1234),
                0, 1, 0, 0, 0, 32'h77, 32'h77,                             1, 0, 0, 0);
        add_vec(0, lw8,                                                    f0,
                0, 1, 0, 0, 32'h100, 32'h1234, 8,                          1, 8, 1, 0);
        add_vec(0, add9,                                                   f0,
                1, 1, 0, 0, 32'h200, 3, 0,                                 0, 0, 0, 1);
        add_vec(0, add9,                                                   mk_f(1, 8, 0, 0, 0, 0),
                0, 0, 0, 0, 0, 0, 0,                                       1, 9, 0, 1);
        add_vec(0, nop,                                                    mk_f(0, 0, 0, 1, 8, 32'hCAFE),
                0, 1, 1, 0, 32'hCAFE, 4, 4,                                0, 0, 0, 1);
        add_vec(0, lw8,                                                    f0,
                0, 0, 0, 0, 0, 0, 0,                                       1, 8, 1, 1);
        add_vec(1, add9,                                                   f0,
                0, 1, 0, 0, 32'h200, 3, 0,                                 0, 0, 0, 1);
        add_vec(0, lw8,                                                    f0,
                0, 0, 0, 0, 0, 0, 0,                                       1, 8, 1, 1);
        add_vec(0, or11,                                                   f0,
                1, 1, 0, 0, 32'h200, 3, 0,                                 0, 0, 0, 2);
        add_vec(0, or11,                                                   f0,
                0, 0, 0, 0, 0, 0, 0,                                       1, 11, 0, 2);
        add_vec(0, lw8,                                                    mk_f(0, 0, 0, 1, 8, 32'hCAFE),
                0, 1, 0, 1, 1, 32'hCAFE, 32'hCAFE,                         1, 8, 1, 2);
        add_vec(0, mk_i(1, 1, 8, 0, 1, 0, 32'h20, 12, 1, 0, 0, 1, 2),      f0,
                0, 1, 0, 0, 32'h200, 32'hCAFE, 0,                          1, 12, 0, 2);

        // Reset state
        reset = 1'b1;
        drive(0, nop, f0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset ex_valid", 32'(bus.ex_valid), 0);
        chk("reset ex_dest", 32'(bus.ex_dest), 0);
        chk("reset ex_memread", 32'(bus.ex_memread), 0);
        chk("reset ex_opa", bus.ex_opa, 0);
        chk("reset bubble_cnt", 32'(bus.bubble_cnt), 0);
        chk("reset stall", 32'(bus.stall), 0);

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.flush, v.id, v.f);
            #1;
            chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(v.e_stall));
            chk($sformatf("v%0d fwd_a", i), 32'(bus.fwd_a), 32'(v.e_fa));
            chk($sformatf("v%0d fwd_b", i), 32'(bus.fwd_b), 32'(v.e_fb));
            if (v.chk_ops) begin
                chk($sformatf("v%0d ex_opa", i), bus.ex_opa, v.e_opa);
                chk($sformatf("v%0d ex_rt_val", i), bus.ex_rt_val, v.e_rtv);
                chk($sformatf("v%0d ex_opb", i), bus.ex_opb, v.e_opb);
            end
            e.idx = i; e.v = v.n_v; e.d = v.n_d; e.mr = v.n_mr; e.cnt = v.n_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d next ex_valid", e.idx), 32'(bus.ex_valid), 32'(e.v));
            chk($sformatf("v%0d next ex_dest", e.idx), 32'(bus.ex_dest), 32'(e.d));
            chk($sformatf("v%0d next ex_memread", e.idx), 32'(bus.ex_memread), 32'(e.mr));
            chk($sformatf("v%0d next bubble_cnt", e.idx), 32'(bus.bubble_cnt), 32'(e.cnt));
        end
        chk("scoreboard drained", sb.size(), 0);

        // Double hazard: EX/MEM wins, then MEM/WB once EX/MEM stops writing
        drive(0, addi6, f0);
        @(posedge clk);
        #1 drive(0, nop, mk_f(1, 7, 32'hAA, 1, 7, 32'hBB));
        #1;
        chk("dbl fwd_a exmem", 32'(bus.fwd_a), 2);
        chk("dbl ex_opa exmem", bus.ex_opa, 32'hAA);
        chk("dbl fwd_b r0", 32'(bus.fwd_b), 0);
        chk("dbl ex_opb imm", bus.ex_opb, 32'h20);
        bus.exmem_regwrite = 1'b0;
        #1;
        chk("dbl fwd_a memwb", 32'(bus.fwd_a), 1);
        chk("dbl ex_opa memwb", bus.ex_opa, 32'hBB);

        // Reset asserted in a stall cycle
        drive(0, lw8, f0);
        @(posedge clk);
        #1 drive(0, add9, f0);
        #1;
        chk("rst-stall stall before", 32'(bus.stall), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst-stall ex_valid", 32'(bus.ex_valid), 0);
        chk("rst-stall ex_memread", 32'(bus.ex_memread), 0);
        chk("rst-stall ex_dest", 32'(bus.ex_dest), 0);
        chk("rst-stall ex_imm", bus.ex_imm, 0);
        chk("rst-stall bubble_cnt", 32'(bus.bubble_cnt), 0);
        chk("rst-stall stall after", 32'(bus.stall), 0);

        // Five load-use stalls saturate a 2-bit counter at 3
        for (int k = 1; k <= 5; k++) begin
            drive(0, lw8, f0);
            @(posedge clk);
            #1 drive(0, add9, f0);
            #1;
            chk($sformatf("sat%0d stall", k), 32'(bus.stall), 1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d bubble_cnt", k), 32'(bus.bubble_cnt), (k > 3) ? 3 : k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
